wb_stage_buffered: RTL and testbench
====================================

# wb_stage_buffered

Registered, parametrised write-back stage for the pipelined ARM core, used where the data memory answers loads with variable latency. It accepts one retiring instruction per cycle from the memory stage over a valid/ready handshake, waits for the load response when needed, performs byte/halfword extraction with optional sign extension, and drives a registered one-cycle write-back commit to the register file. A saturating counter records the number of cycles stalled on memory.

## Interface
- DATA_WIDTH, 32, datapath width; only 32 is legal, since the sub-word lane logic assumes 4 bytes.
- REG_ADDR_WIDTH, 4, register-file index width.
- STALL_CNT_WIDTH, 16, width of the stall counter.

- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_Valid  input  1  memory stage presents an instruction.
- o_Ready  output  1  stage can accept; equals (state == IDLE).
- i_Pc  input  DATA_WIDTH  PC of the presented instruction.
- i_Sig_Write_Back_Enable  input  1  instruction writes a register.
- i_Sig_Memory_Read_Enable  input  1  instruction is a load.
- i_Load_Size  input  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- i_Load_Signed  input  1  sign-extend sub-word loads.
- i_Addr_Low  input  2  byte offset of the load address.
- i_ALU_Result  input  DATA_WIDTH  non-load result.
- i_Destination  input  REG_ADDR_WIDTH  destination register.
- i_Data_Memory  input  DATA_WIDTH  load data word.
- i_Data_Memory_Valid  input  1  i_Data_Memory valid this cycle.
- o_Pc  output  DATA_WIDTH  PC of the committed instruction.
- o_Sig_Write_Back_Enable  output  1  one-cycle register-file write strobe.
- o_Write_Back_Value  output  DATA_WIDTH  value written.
- o_Destination  output  REG_ADDR_WIDTH  register written.
- o_Misaligned  output  1  one-cycle pulse: the committed load was misaligned and its write was suppressed.
- o_Stall_Count  output  STALL_CNT_WIDTH  saturating count of WAIT_MEM cycles.

## Operation
- Accept happens when i_Valid and o_Ready are both high on a rising edge.
- States:
  - **IDLE**: on accept of a non-load, commit on that edge. On accept of a load with i_Data_Memory_Valid high in the same cycle, commit on that edge. On accept of a load without i_Data_Memory_Valid, capture Pc, destination, size, signed flag, offset and write-back enable into holding registers, then go to WAIT_MEM.
  - **WAIT_MEM**: o_Ready = 0. The stall counter increments each cycle, saturating at all-ones. On i_Data_Memory_Valid, commit using the held fields and return to IDLE.
  - i_Data_Memory_Valid seen in IDLE without an accepted load is ignored.
- Commit: registers o_Pc, o_Destination and o_Write_Back_Value. o_Sig_Write_Back_Enable equals the instruction's write-back enable AND NOT misaligned.
- Load extraction (on i_Data_Memory):
  - **Word**: whole word; misaligned if offset != 0.
  - **Halfword**: bits [15:0] if offset[1] = 0, else bits [31:16]; misaligned if offset[0] = 1.
  - **Byte**: lane offset×8 +: 8; never misaligned.
- Sub-word results are zero-extended, or sign-extended from the lane MSB when i_Load_Signed = 1.
- Non-loads write i_ALU_Result; i_Load_Size, i_Load_Signed and i_Addr_Low are ignored and o_Misaligned stays 0.
- o_Misaligned pulses on the commit of a misaligned load. The value register is still updated with the extracted data; only the write strobe is suppressed.
- In cycles with no commit, o_Sig_Write_Back_Enable and o_Misaligned are 0. o_Pc, o_Destination and o_Write_Back_Value hold their last values.

## Timing
- Reset (reset = 0, asynchronous) takes effect immediately:
  - state = IDLE;
  - every output register = 0, including o_Stall_Count;
  - o_Ready = 1 once state is IDLE.
- Latency: non-load or same-cycle-data load is visible at the outputs 1 cycle after accept. A delayed load is visible 1 cycle after the i_Data_Memory_Valid edge.
- Throughput: 1 instruction per cycle while there are no memory waits.
- o_Ready is combinational from state and drops the cycle after a waiting load is accepted.
- Reset asserted in WAIT_MEM drops the pending load: no commit occurs and the holding registers clear.
- Stall counter saturation: at all-ones it holds, with no wrap.

## Test plan
- **Non-load back-to-back.** Accept ALU results 0x11, 0x22 to r3 and r4 on consecutive cycles. Required: write strobes on the next two cycles with values 0x11/r3 and 0x22/r4; o_Ready stays 1.
- **Delayed signed byte.** Load byte, signed, offset 2; memory data 0x0080_0000 arrives 3 cycles later. Required: o_Ready = 0 for 3 cycles; commit 0xFFFF_FF80; o_Stall_Count = 3.
- **Unsigned halfword, same cycle.** Load halfword, unsigned, offset 2, data 0xBEEF_1234, valid in the same cycle. Required: next-cycle commit 0x0000_BEEF with no stall.
- **Misaligned word.** Load word, offset 1, write-back enable 1, dest r5. Required: o_Misaligned = 1 and o_Sig_Write_Back_Enable = 0 on the commit cycle.
- **Reset during wait.** Drive reset low during WAIT_MEM, then assert i_Data_Memory_Valid after reset is released. Required: all outputs 0, o_Ready = 1, no commit.
- **Counter saturation.** With STALL_CNT_WIDTH = 2, a 6-cycle memory wait. Required: o_Stall_Count ends at 3.

Source files
------------

// File: rtl/wb_stage_buffered.sv
// Write-back stage: commits ALU results or extracted load data to the register file, waiting on slow memory.
// Latency: 1 cycle from accept (or from load-data arrival when the load had to wait).
// Backpressure: o_Ready drops while a load waits for memory; one instruction per cycle otherwise.
module wb_stage_buffered #(
    parameter int DATA_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH  = 4,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_Valid,
    output logic                       o_Ready,
    input  logic [DATA_WIDTH-1:0]      i_Pc,
    input  logic                       i_Sig_Write_Back_Enable,
    input  logic                       i_Sig_Memory_Read_Enable,
    input  logic [1:0]                 i_Load_Size,
    input  logic                       i_Load_Signed,
    input  logic [1:0]                 i_Addr_Low,
    input  logic [DATA_WIDTH-1:0]      i_ALU_Result,
    input  logic [REG_ADDR_WIDTH-1:0]  i_Destination,
    input  logic [DATA_WIDTH-1:0]      i_Data_Memory,
    input  logic                       i_Data_Memory_Valid,
    output logic [DATA_WIDTH-1:0]      o_Pc,
    output logic                       o_Sig_Write_Back_Enable,
    output logic [DATA_WIDTH-1:0]      o_Write_Back_Value,
    output logic [REG_ADDR_WIDTH-1:0]  o_Destination,
    output logic                       o_Misaligned,
    output logic [STALL_CNT_WIDTH-1:0] o_Stall_Count
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Fields of a load that is waiting for its memory response
    logic [DATA_WIDTH-1:0]     hold_pc_q;
    logic [REG_ADDR_WIDTH-1:0] hold_dest_q;
    logic [1:0]                hold_size_q;
    logic                      hold_signed_q;
    logic [1:0]                hold_off_q;
    logic                      hold_wbe_q;

    // Output registers
    logic [DATA_WIDTH-1:0]      pc_q;
    logic [DATA_WIDTH-1:0]      val_q;
    logic [REG_ADDR_WIDTH-1:0]  dest_q;
    logic                       wbe_q;
    logic                       mis_q;
    logic [STALL_CNT_WIDTH-1:0] cnt_q;

    // Commit-side selection: live inputs in IDLE, held fields in WAIT_MEM
    logic                      capture;
    logic                      commit;
    logic                      c_load;
    logic [DATA_WIDTH-1:0]     c_pc;
    logic [REG_ADDR_WIDTH-1:0] c_dest;
    logic [1:0]                c_size;
    logic                      c_signed;
    logic [1:0]                c_off;
    logic                      c_wbe;

    logic [7:0]            lane8;
    logic [15:0]           lane16;
    logic [DATA_WIDTH-1:0] ext_val;
    logic                  ext_mis;
    logic [DATA_WIDTH-1:0] wb_val;
    logic                  wb_mis;

    assign o_Ready = (state_q == IDLE);

    // Next state, capture/commit decisions and selection of the committing instruction's fields
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        commit   = 1'b0;
        c_load   = 1'b0;
        c_pc     = i_Pc;
        c_dest   = i_Destination;
        c_size   = i_Load_Size;
        c_signed = i_Load_Signed;
        c_off    = i_Addr_Low;
        c_wbe    = i_Sig_Write_Back_Enable;
        case (state_q)
            IDLE: begin
                if (i_Valid) begin
                    if (!i_Sig_Memory_Read_Enable) begin
                        commit = 1'b1;
                    end else if (i_Data_Memory_Valid) begin
                        commit = 1'b1;
                        c_load = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_d = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                c_load   = 1'b1;
                c_pc     = hold_pc_q;
                c_dest   = hold_dest_q;
                c_size   = hold_size_q;
                c_signed = hold_signed_q;
                c_off    = hold_off_q;
                c_wbe    = hold_wbe_q;
                if (i_Data_Memory_Valid) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sub-word lane extraction, extension and alignment check; reserved size behaves as word
    always_comb begin
        lane8   = i_Data_Memory[7:0];
        lane16  = c_off[1] ? i_Data_Memory[31:16] : i_Data_Memory[15:0];
        ext_val = i_Data_Memory;
        ext_mis = (c_off != 2'b00);
        case (c_off)
            2'd0: lane8 = i_Data_Memory[7:0];
            2'd1: lane8 = i_Data_Memory[15:8];
            2'd2: lane8 = i_Data_Memory[23:16];
            2'd3: lane8 = i_Data_Memory[31:24];
            default: lane8 = i_Data_Memory[7:0];
        endcase
        case (c_size)
            2'b01: begin
                ext_val = {{(DATA_WIDTH-16){c_signed & lane16[15]}}, lane16};
                ext_mis = c_off[0];
            end
            2'b10: begin
                ext_val = {{(DATA_WIDTH-8){c_signed & lane8[7]}}, lane8};
                ext_mis = 1'b0;
            end
            default: begin
                ext_val = i_Data_Memory;
                ext_mis = (c_off != 2'b00);
            end
        endcase
        wb_val = c_load ? ext_val : i_ALU_Result;
        wb_mis = c_load & ext_mis;
    end

    // State register and holding registers for a waiting load; reset drops any pending load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            hold_pc_q     <= '0;
            hold_dest_q   <= '0;
            hold_size_q   <= '0;
            hold_signed_q <= 1'b0;
            hold_off_q    <= '0;
            hold_wbe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hold_pc_q     <= i_Pc;
                hold_dest_q   <= i_Destination;
                hold_size_q   <= i_Load_Size;
                hold_signed_q <= i_Load_Signed;
                hold_off_q    <= i_Addr_Low;
                hold_wbe_q    <= i_Sig_Write_Back_Enable;
            end
        end
    end

    // Registered commit: strobes pulse for one cycle, data fields hold between commits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= '0;
            val_q  <= '0;
            dest_q <= '0;
            wbe_q  <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            wbe_q <= commit & c_wbe & ~wb_mis;
            mis_q <= commit & wb_mis;
            if (commit) begin
                pc_q   <= c_pc;
                val_q  <= wb_val;
                dest_q <= c_dest;
            end
        end
    end

    // Saturating count of cycles spent waiting on memory
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q == WAIT_MEM && cnt_q != {STALL_CNT_WIDTH{1'b1}}) begin
            cnt_q <= cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    assign o_Pc                    = pc_q;
    assign o_Write_Back_Value      = val_q;
    assign o_Destination           = dest_q;
    assign o_Sig_Write_Back_Enable = wbe_q;
    assign o_Misaligned            = mis_q;
    assign o_Stall_Count           = cnt_q;

endmodule

// File: tb/tb_wb_stage_buffered.sv
module tb_wb_stage_buffered;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_Valid = 1'b0;
    logic [31:0] i_Pc = '0;
    logic        i_Sig_Write_Back_Enable = 1'b0;
    logic        i_Sig_Memory_Read_Enable = 1'b0;
    logic [1:0]  i_Load_Size = '0;
    logic        i_Load_Signed = 1'b0;
    logic [1:0]  i_Addr_Low = '0;
    logic [31:0] i_ALU_Result = '0;
    logic [3:0]  i_Destination = '0;
    logic [31:0] i_Data_Memory = '0;
    logic        i_Data_Memory_Valid = 1'b0;

    logic        o_Ready, s_Ready;
    logic [31:0] o_Pc, s_Pc;
    logic        o_Sig_Write_Back_Enable, s_Sig_Write_Back_Enable;
    logic [31:0] o_Write_Back_Value, s_Write_Back_Value;
    logic [3:0]  o_Destination, s_Destination;
    logic        o_Misaligned, s_Misaligned;
    logic [15:0] o_Stall_Count;
    logic [1:0]  s_Stall_Count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_stage_buffered #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .STALL_CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .i_Valid(i_Valid), .o_Ready(o_Ready), .i_Pc(i_Pc),
        .i_Sig_Write_Back_Enable(i_Sig_Write_Back_Enable),
        .i_Sig_Memory_Read_Enable(i_Sig_Memory_Read_Enable),
        .i_Load_Size(i_Load_Size), .i_Load_Signed(i_Load_Signed), .i_Addr_Low(i_Addr_Low),
        .i_ALU_Result(i_ALU_Result), .i_Destination(i_Destination),
        .i_Data_Memory(i_Data_Memory), .i_Data_Memory_Valid(i_Data_Memory_Valid),
        .o_Pc(o_Pc), .o_Sig_Write_Back_Enable(o_Sig_Write_Back_Enable),
        .o_Write_Back_Value(o_Write_Back_Value), .o_Destination(o_Destination),
        .o_Misaligned(o_Misaligned), .o_Stall_Count(o_Stall_Count)
    );

    // Narrow stall counter instance sharing the same stimulus, for saturation checks
    wb_stage_buffered #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .STALL_CNT_WIDTH(2)) u_sat (
        .clk(clk), .reset(reset), .i_Valid(i_Valid), .o_Ready(s_Ready), .i_Pc(i_Pc),
        .i_Sig_Write_Back_Enable(i_Sig_Write_Back_Enable),
        .i_Sig_Memory_Read_Enable(i_Sig_Memory_Read_Enable),
        .i_Load_Size(i_Load_Size), .i_Load_Signed(i_Load_Signed), .i_Addr_Low(i_Addr_Low),
        .i_ALU_Result(i_ALU_Result), .i_Destination(i_Destination),
        .i_Data_Memory(i_Data_Memory), .i_Data_Memory_Valid(i_Data_Memory_Valid),
        .o_Pc(s_Pc), .o_Sig_Write_Back_Enable(s_Sig_Write_Back_Enable),
        .o_Write_Back_Value(s_Write_Back_Value), .o_Destination(s_Destination),
        .o_Misaligned(s_Misaligned), .o_Stall_Count(s_Stall_Count)
    );

    typedef struct {
        logic        is_load;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic        wbe;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [3:0]  dest;
        logic [31:0] exp_val;
        logic        exp_wbe;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic        is_load;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic        wbe;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [3:0]  dest;
    } instr_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [1:0] off, input logic wbe, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [3:0] dst,
                         input logic dmv, input logic [31:0] mem);
        i_Valid = v; i_Sig_Memory_Read_Enable = ld; i_Load_Size = sz; i_Load_Signed = sg;
        i_Addr_Low = off; i_Sig_Write_Back_Enable = wbe; i_ALU_Result = alu; i_Pc = pc;
        i_Destination = dst; i_Data_Memory_Valid = dmv; i_Data_Memory = mem;
    endtask

    task automatic idle_inputs();
        i_Valid = 1'b0;
        i_Data_Memory_Valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Reference load extraction written directly from the size/offset/sign rules
    function automatic void ref_load(input logic [1:0] size, input logic sgn, input logic [1:0] off,
                                     input logic [31:0] d, output logic [31:0] v, output logic mis);
        int unsigned x;
        int unsigned dd;
        dd = d;
        if (size == 2'b01) begin
            x = off[1] ? (dd / 65536) : (dd % 65536);
            if (sgn && x >= 32768) x = x + 32'hFFFF0000;
            mis = off[0];
        end else if (size == 2'b10) begin
            x = (dd >> (8 * int'(off))) % 256;
            if (sgn && x >= 128) x = x + 32'hFFFFFF00;
            mis = 1'b0;
        end else begin
            x = dd;
            mis = (off != 2'b00);
        end
        v = x;
    endfunction

    vec_t vecs[15];

    // Random-test model state
    bit          m_busy;
    instr_t      m_pend;
    int          m_cnt;
    logic [31:0] e_pc, e_val;
    logic [3:0]  e_dest;
    logic        e_wbe, e_mis;

    task automatic model_commit(input instr_t t, input logic [31:0] mem);
        logic [31:0] v;
        logic        mis;
        if (t.is_load) ref_load(t.size, t.sgn, t.off, mem, v, mis);
        else begin
            v = t.alu;
            mis = 1'b0;
        end
        e_pc = t.pc; e_dest = t.dest; e_val = v;
        e_mis = mis; e_wbe = t.wbe & ~mis;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'b01, 1'b1, 2'd3, 1'b1, 32'hDEADBEEF, 32'h0,        4'd1,  32'hDEADBEEF, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 2'b00, 1'b0, 2'd0, 1'b1, 32'h0,        32'h89ABCDEF, 4'd2,  32'h89ABCDEF, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 2'd1, 1'b1, 32'h0,        32'h12345678, 4'd5,  32'h12345678, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 2'd2, 1'b1, 32'h0,        32'hBEEF1234, 4'd6,  32'h0000BEEF, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 1'b1, 2'd0, 1'b1, 32'h0,        32'h12348001, 4'd7,  32'hFFFF8001, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 1'b1, 2'd2, 1'b1, 32'h0,        32'h7FFF8000, 4'd8,  32'h00007FFF, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 2'd3, 1'b1, 32'h0,        32'hAABBCCDD, 4'd9,  32'h0000AABB, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 2'd0, 1'b1, 32'h0,        32'h11223344, 4'd10, 32'h00000044, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 2'b10, 1'b1, 2'd1, 1'b1, 32'h0,        32'h1122B344, 4'd11, 32'hFFFFFFB3, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 2'b10, 1'b1, 2'd3, 1'b1, 32'h0,        32'h80000000, 4'd12, 32'hFFFFFF80, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 2'd3, 1'b1, 32'h0,        32'h80000000, 4'd13, 32'h00000080, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 2'b11, 1'b1, 2'd0, 1'b1, 32'h0,        32'hCAFEF00D, 4'd14, 32'hCAFEF00D, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 2'b11, 1'b0, 2'd2, 1'b1, 32'h0,        32'h01020304, 4'd15, 32'h01020304, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 2'b10, 1'b0, 2'd2, 1'b0, 32'h0,        32'h00FF0000, 4'd4,  32'h000000FF, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 32'h00000005, 32'hFFFFFFFF, 4'd3,  32'h00000005, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_ready", o_Ready, 1);
        chk("rst_wbe", o_Sig_Write_Back_Enable, 0);
        chk("rst_val", o_Write_Back_Value, 0);
        chk("rst_pc", o_Pc, 0);
        chk("rst_dest", o_Destination, 0);
        chk("rst_mis", o_Misaligned, 0);
        chk("rst_cnt", o_Stall_Count, 0);
        tick();
        reset = 1'b1;
        tick();

        // Table: single-cycle commits (non-load or same-cycle data)
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vecs[i].is_load, vecs[i].size, vecs[i].sgn, vecs[i].off, vecs[i].wbe,
                  vecs[i].alu, 32'h1000 + 32'(i * 4), vecs[i].dest, 1'b1, vecs[i].mem);
            chk($sformatf("vec%0d_ready", i), o_Ready, 1);
            tick();
            chk($sformatf("vec%0d_val", i), o_Write_Back_Value, vecs[i].exp_val);
            chk($sformatf("vec%0d_wbe", i), o_Sig_Write_Back_Enable, vecs[i].exp_wbe);
            chk($sformatf("vec%0d_mis", i), o_Misaligned, vecs[i].exp_mis);
            chk($sformatf("vec%0d_dest", i), o_Destination, vecs[i].dest);
            chk($sformatf("vec%0d_pc", i), o_Pc, 32'h1000 + 32'(i * 4));
        end
        idle_inputs();
        tick();
        chk("vec_after_wbe", o_Sig_Write_Back_Enable, 0);
        chk("vec_after_hold", o_Write_Back_Value, 32'h5);
        chk("vec_no_stall", o_Stall_Count, 0);

        // Back-to-back non-loads
        drive(1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 32'h11, 32'h40, 4'd3, 1'b0, 32'h0);
        tick();
        chk("b2b_ready1", o_Ready, 1);
        chk("b2b_wbe1", o_Sig_Write_Back_Enable, 1);
        chk("b2b_val1", o_Write_Back_Value, 32'h11);
        chk("b2b_dest1", o_Destination, 3);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 32'h22, 32'h44, 4'd4, 1'b0, 32'h0);
        tick();
        chk("b2b_ready2", o_Ready, 1);
        chk("b2b_wbe2", o_Sig_Write_Back_Enable, 1);
        chk("b2b_val2", o_Write_Back_Value, 32'h22);
        chk("b2b_dest2", o_Destination, 4);
        idle_inputs();
        tick();
        chk("b2b_idle_wbe", o_Sig_Write_Back_Enable, 0);

        // Delayed signed byte load, data 3 cycles later
        do_reset();
        drive(1'b1, 1'b1, 2'b10, 1'b1, 2'd2, 1'b1, 32'h0, 32'h200, 4'd7, 1'b0, 32'hFFFFFFFF);
        tick();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 32'h99, 32'h999, 4'd1, 1'b0, 32'hFFFFFFFF);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dly_ready%0d", k), o_Ready, 0);
            chk($sformatf("dly_wbe%0d", k), o_Sig_Write_Back_Enable, 0);
            if (k == 2) begin
                i_Data_Memory_Valid = 1'b1;
                i_Data_Memory = 32'h00800000;
            end
            tick();
        end
        idle_inputs();
        chk("dly_wbe", o_Sig_Write_Back_Enable, 1);
        chk("dly_val", o_Write_Back_Value, 32'hFFFFFF80);
        chk("dly_dest", o_Destination, 7);
        chk("dly_pc", o_Pc, 32'h200);
        chk("dly_cnt", o_Stall_Count, 3);
        chk("dly_ready_back", o_Ready, 1);

        // Reset asserted while a load waits
        do_reset();
        drive(1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 1'b1, 32'h0, 32'h300, 4'd9, 1'b0, 32'h0);
        tick();
        idle_inputs();
        chk("rw_ready_low", o_Ready, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rw_async_ready", o_Ready, 1);
        chk("rw_async_cnt", o_Stall_Count, 0);
        tick();
        reset = 1'b1;
        i_Data_Memory_Valid = 1'b1;
        i_Data_Memory = 32'h00001234;
        tick();
        idle_inputs();
        chk("rw_wbe", o_Sig_Write_Back_Enable, 0);
        chk("rw_mis", o_Misaligned, 0);
        chk("rw_val", o_Write_Back_Value, 0);
        chk("rw_pc", o_Pc, 0);
        chk("rw_dest", o_Destination, 0);
        chk("rw_ready", o_Ready, 1);
        chk("rw_cnt", o_Stall_Count, 0);

        // 6-cycle wait: narrow counter saturates at 3
        do_reset();
        drive(1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 1'b1, 32'h0, 32'h400, 4'd2, 1'b0, 32'h0);
        tick();
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("sat_ready%0d", k), s_Ready, 0);
            if (k == 5) begin
                i_Data_Memory_Valid = 1'b1;
                i_Data_Memory = 32'h0BADF00D;
            end
            tick();
            chk($sformatf("sat_cnt%0d", k), s_Stall_Count, (k + 1 > 3) ? 3 : k + 1);
        end
        idle_inputs();
        chk("sat_final", s_Stall_Count, 3);
        chk("sat_wide_cnt", o_Stall_Count, 6);
        chk("sat_commit", s_Sig_Write_Back_Enable, 1);
        chk("sat_val", s_Write_Back_Value, 32'h0BADF00D);
        tick();
        chk("sat_hold", s_Stall_Count, 3);

        // Randomized traffic against the reference model
        do_reset();
        m_busy = 0; m_cnt = 0;
        e_pc = '0; e_val = '0; e_dest = '0; e_wbe = 1'b0; e_mis = 1'b0;
        for (int c = 0; c < 500; c++) begin
            instr_t t;
            logic   v, dmv;
            logic [31:0] mem;
            v   = ($urandom_range(3) != 0);
            dmv = ($urandom_range(2) == 0);
            mem = $urandom;
            t.is_load = $urandom_range(1);
            t.size = 2'($urandom_range(3));
            t.sgn  = 1'($urandom_range(1));
            t.off  = 2'($urandom_range(3));
            t.wbe  = ($urandom_range(4) != 0);
            t.alu  = $urandom;
            t.pc   = $urandom;
            t.dest = 4'($urandom_range(15));
            drive(v, t.is_load, t.size, t.sgn, t.off, t.wbe, t.alu, t.pc, t.dest, dmv, mem);
            chk("rnd_ready", o_Ready, !m_busy);
            e_wbe = 1'b0;
            e_mis = 1'b0;
            if (!m_busy) begin
                if (v) begin
                    if (!t.is_load || dmv) model_commit(t, mem);
                    else begin
                        m_busy = 1;
                        m_pend = t;
                    end
                end
            end else begin
                if (m_cnt < 65535) m_cnt++;
                if (dmv) begin
                    model_commit(m_pend, mem);
                    m_busy = 0;
                end
            end
            tick();
            chk("rnd_wbe", o_Sig_Write_Back_Enable, e_wbe);
            chk("rnd_mis", o_Misaligned, e_mis);
            chk("rnd_val", o_Write_Back_Value, e_val);
            chk("rnd_dest", o_Destination, e_dest);
            chk("rnd_pc", o_Pc, e_pc);
            chk("rnd_cnt", o_Stall_Count, m_cnt);
            chk("rnd_sat_cnt", s_Stall_Count, (m_cnt > 3) ? 3 : m_cnt);
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
